// File: rtl/delay_line_arbiter.sv
// Shares one external Queue2 delay line among 4 requesters.
// Round-robin grant with per-requester credits.
// A tag pipe runs in lockstep with the line, so each sample leaves tagged.
// Ports:
//   clock, reset        : clock, sync active-high reset
//   req_valid/req_ready : per-requester handshake
//   req_data            : requester i data at [i*WIDTH +: WIDTH]
//   q_in / q_out        : to/from the Queue2 instance
//   out_valid/out_tag   : delayed sample is real, and its source
//   out_data            : q_out passed through
//   busy                : any requester has samples in flight
module delay_line_arbiter #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 16,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int              CREDITS = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic [WIDTH-1:0]   q_in,
  input  logic [WIDTH-1:0]   q_out,
  output logic               out_valid,
  output logic [1:0]         out_tag,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [1:0]       ptr;
  logic [CW-1:0]    cnt [4];
  logic [DEPTH-1:0] vpipe;
  logic [1:0]       tpipe [DEPTH];

  logic [3:0] elig;
  logic [3:0] leave;
  logic [1:0] idx;
  logic       grant_any;
  logic [1:0] grant_idx;

  assign out_valid = vpipe[DEPTH-1];
  assign out_tag   = tpipe[DEPTH-1];
  assign out_data  = q_out;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < 4; i++)
      busy = busy | (cnt[i] != '0);
  end

  // A slot being freed this cycle can be reused in the same cycle,
  // so a full requester is released on the edge its sample leaves.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    idx       = '0;
    for (int i = 0; i < 4; i++) begin
      leave[i] = out_valid && (out_tag == 2'(i));
      elig[i]  = !reset && req_valid[i] &&
                 ((cnt[i] < CW'(CREDITS)) || leave[i]);
    end
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    q_in = INIT;
    if (grant_any)
      q_in = req_data[grant_idx*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      vpipe <= '0;
      for (int s = 0; s < DEPTH; s++)
        tpipe[s] <= '0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= '0;
    end else begin
      if (grant_any)
        ptr <= grant_idx + 2'd1;
      vpipe    <= {vpipe[DEPTH-2:0], grant_any};
      tpipe[0] <= grant_idx;
      for (int s = 1; s < DEPTH; s++)
        tpipe[s] <= tpipe[s-1];
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && !leave[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (leave[i] && !req_ready[i])
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Randomized and directed bench for delay_line_arbiter.
// Includes a Queue2 stand-in and a history-based reference model.
module tb_delay_line_arbiter;

  localparam int W = 8;
  localparam int D = 16;
  localparam int C = 2;
  localparam int MAXC = 8192;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]   req_ready;
  logic [W-1:0] q_in;
  logic [W-1:0] q_out;
  logic         out_valid;
  logic [1:0]   out_tag;
  logic [W-1:0] out_data;
  logic         busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  delay_line_arbiter #(
    .WIDTH(W), .DEPTH(D), .INIT(8'h00), .CREDITS(C)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .q_in(q_in), .q_out(q_out),
    .out_valid(out_valid), .out_tag(out_tag),
    .out_data(out_data), .busy(busy)
  );

  // Queue2 stand-in: DEPTH-stage shift register cleared by reset.
  logic [W-1:0] qline [D];
  assign q_out = qline[D-1];
  always @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < D; s++) qline[s] <= 8'h00;
    end else begin
      qline[0] <= q_in;
      for (int s = 1; s < D; s++) qline[s] <= qline[s-1];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a log of which requester was granted on each
  // cycle. A sample granted on cycle g is in flight for cycles g+1
  // to g+D and is seen at the output on cycle g+D.
  bit           gv [MAXC];
  logic [1:0]   gt [MAXC];
  logic [W-1:0] gd [MAXC];
  int cyc = 0;
  int base = 0;
  int mptr = 0;
  int ov_count;
  int ov_first;

  function automatic int inflight(int who, int lo, int hi);
    int n = 0;
    for (int g = lo; g <= hi; g++)
      if (g >= base && g >= 0 && gv[g] && gt[g] == who[1:0]) n++;
    return n;
  endfunction

  task automatic cycle(input logic [3:0] v,
                       input logic [4*W-1:0] d,
                       input logic r);
    int win;
    logic [3:0] exp_rdy;
    logic exp_ov;
    logic exp_busy;
    reset = r;
    req_valid = v;
    req_data = d;
    @(negedge clock);
    exp_ov = (cyc - D >= base) && gv[cyc-D];
    exp_busy = 1'b0;
    for (int i = 0; i < 4; i++)
      if (inflight(i, cyc - D, cyc - 1) != 0) exp_busy = 1'b1;
    win = -1;
    if (!r) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (mptr + k) % 4;
        if (win < 0 && v[i] &&
            inflight(i, cyc - D + 1, cyc - 1) < C)
          win = i;
      end
    end
    exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (exp_ov) begin
      chk("out_tag", 32'(out_tag), 32'(gt[cyc-D]));
      chk("out_data", 32'(out_data), 32'(gd[cyc-D]));
    end
    if (!r) begin
      if (win >= 0)
        chk("q_in", 32'(q_in), 32'(d[win*W +: W]));
      else
        chk("q_in_idle", 32'(q_in), 32'h0);
    end
    if (out_valid) begin
      if (ov_count == 0) ov_first = cyc;
      ov_count++;
    end
    gv[cyc] = (win >= 0);
    gt[cyc] = (win >= 0) ? 2'(win) : 2'd0;
    gd[cyc] = (win >= 0) ? d[win*W +: W] : 8'h00;
    if (win >= 0) mptr = (win + 1) % 4;
    if (r) begin
      base = cyc + 1;
      mptr = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  logic [4*W-1:0] rot_data;
  logic [4*W-1:0] rdata;
  int start;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    @(posedge clock);
    #1;
    cycle(4'hF, 32'h0, 1'b1);
    cycle(4'hF, 32'h0, 1'b1);

    // Single sample.
    ov_count = 0;
    start = cyc;
    cycle(4'b0001, 32'h0000005A, 1'b0);
    for (int n = 0; n < 20; n++) cycle(4'b0, 32'h0, 1'b0);
    chk("single_count", 32'(ov_count), 32'd1);
    chk("single_latency", 32'(ov_first - start), 32'(D));
    chk("single_busy", 32'(busy), 32'd0);

    // Rotation with all four requesters.
    cycle(4'h0, 32'h0, 1'b1);
    rot_data = 32'h13121110;
    for (int n = 0; n < 40; n++) cycle(4'hF, rot_data, 1'b0);

    // Credit stall on requester 2 alone.
    cycle(4'h0, 32'h0, 1'b1);
    for (int n = 0; n < 40; n++)
      cycle(4'b0100, 32'h00AB0000 | 32'(n), 1'b0);

    // Wrap-around priority.
    cycle(4'h0, 32'h0, 1'b1);
    cycle(4'b0100, 32'h00220000, 1'b0);
    cycle(4'b1010, 32'h33001100, 1'b0);
    cycle(4'b1010, 32'h33001100, 1'b0);
    for (int n = 0; n < 20; n++) cycle(4'b0, 32'h0, 1'b0);

    // Reset mid-flight.
    for (int n = 0; n < 5; n++)
      cycle(4'hF, 32'h44332211, 1'b0);
    ov_count = 0;
    cycle(4'h0, 32'h0, 1'b1);
    for (int n = 0; n < 20; n++) cycle(4'b0, 32'h0, 1'b0);
    chk("flush_no_output", 32'(ov_count), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);

    // Alternating bubbles from requester 1.
    for (int n = 0; n < 40; n++)
      cycle((n % 2 == 0) ? 4'b0010 : 4'b0000,
            32'(n) << 8, 1'b0);

    // Random traffic with occasional reset.
    for (int n = 0; n < 2500; n++) begin
      rdata = {$urandom(), $urandom()} & 32'hFFFFFFFF;
      rdata = $urandom();
      cycle(4'($urandom_range(0, 15)), rdata,
            ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
